sm_clk_gen: RTL and testbench
=============================

Name: sm_clk_gen

Overview:
Parametrised successor to the free-running tap clock divider. Generates the CPU clock from clkIn, with RUN, STOP and single-STEP modes. The divide setting changes glitch-free, only at period boundaries. Adds a registered one-cycle tick at each rising edge and a count of output clock periods. Sits between the input metafilters and sm_cpu in the top level. Inputs are already synchronised to clkIn.

Parameters:
SHIFT_MIN, 16, minimum half-period exponent; half-period = 2^(SHIFT_MIN + divActive) clkIn cycles.
DIV_WIDTH, 4, width of the devide input.
CYC_WIDTH, 32, width of the cycleCnt output.
Local HALF_W = SHIFT_MIN + 2^DIV_WIDTH - 1, width of the half-period counter (minimum 1).

Ports:
clkIn     input   1          clock
rst_n     input   1          asynchronous reset, active low
devide    input   DIV_WIDTH  requested divide exponent
mode      input   2          00 STOP, 01 RUN, 10 STEP, 11 treated as STOP
step      input   1          step request; each rising edge asks for one period in STEP mode
clkOut    output  1          generated clock (registered)
clkTick   output  1          one clkIn-cycle pulse coincident with first cycle of each high phase
busy      output  1          1 while a period is in progress (state != IDLE)
cycleCnt  output  CYC_WIDTH  number of clkOut rising edges since reset, wraps

Behaviour:
- Reset (rst_n low, asynchronous) clears all state immediately:
  - state = IDLE; clkOut, clkTick and busy = 0.
  - cycleCnt, halfCnt and divActive = 0.
  - stepPending = 0; stepPrev = 0.
- States:
  - IDLE: clkOut 0.
  - HIGH: clkOut 1.
  - LOW: clkOut 0.
  - clkOut is decoded from the registered state (state == HIGH), so it is glitch-free.
- Step edge detection:
  - stepPrev <= step every cycle.
  - A rising edge (step & ~stepPrev) sets stepPending only when mode == STEP.
  - Edges in any other mode are ignored.
  - At most one request is held pending; further edges while pending are dropped.
- Mode STOP or 11 clears stepPending.
- Start condition:
  - start = (mode == RUN) or (mode == STEP and stepPending).
  - Evaluated in IDLE and at the end of LOW.
- IDLE -> HIGH when start:
  - Capture divActive <= devide; halfCnt <= 0.
  - clkTick <= 1; cycleCnt <= cycleCnt + 1 (wraps modulo 2^CYC_WIDTH).
  - If mode == STEP, clear stepPending.
  - Latency: start seen at clkIn edge k gives clkOut = 1 and clkTick = 1 after edge k.
- HIGH:
  - halfCnt increments each cycle.
  - When halfCnt == 2^(SHIFT_MIN + divActive) - 1, go to LOW with halfCnt <= 0.
- LOW:
  - Same count rule as HIGH.
  - At terminal count: if start, go to HIGH with the same actions as IDLE -> HIGH (new divActive captured here); else go to IDLE.
- clkTick is high for exactly one cycle per HIGH entry; 0 otherwise.
- Glitch-free divide change:
  - devide is sampled only on HIGH entry.
  - Changes mid-period affect the next period only.
  - The high and low phases of any one period are always equal.
- Mode change mid-period (RUN to STOP or STEP):
  - The current period always completes in full; no truncated phase.
  - Then IDLE, unless start holds.
- Minimum period (SHIFT_MIN = 0, devide = 0): 1 cycle high, 1 cycle low; continuous RUN toggles every cycle.
- Back-to-back periods: no IDLE cycle is inserted between LOW terminal and the next HIGH.

Test Plan:
1. SHIFT_MIN=0. Assert rst_n low for 3 cycles with mode=RUN -> clkOut, clkTick, busy and cycleCnt all 0 during reset; first clkOut=1 on the first edge after release.
2. SHIFT_MIN=0, RUN, devide=0, run 20 cycles -> clkOut pattern 1,0,1,0...; clkTick high on every other cycle; cycleCnt = 10.
3. SHIFT_MIN=0, RUN, devide=2; change devide to 1 on cycle 2 of a high phase -> that period stays 4 high / 4 low; the next period is 2 high / 2 low.
4. SHIFT_MIN=0, STEP, devide=1, single step pulse -> exactly one period (2 high, 2 low), then IDLE with busy=0 and cycleCnt +1. Three step edges within one period -> exactly 2 periods total. Step edges while mode=RUN -> no extra period after switching to STEP.
5. SHIFT_MIN=0, RUN, devide=3; switch mode to STOP on cycle 3 of HIGH -> HIGH completes 8 cycles, LOW completes 8 cycles, then clkOut stays 0 and busy=0.
6. Drop rst_n asynchronously mid-HIGH (between clkIn edges) -> clkOut and cycleCnt are 0 before the next clkIn edge; after release the block restarts cleanly.

Source files
------------

// File: rtl/sm_clk_gen.sv
// -----------------------------------------------------------------------------
// sm_clk_gen
//
// Programmable CPU clock generator. Divides clkIn down to clkOut with a
// half-period of 2^(SHIFT_MIN + divActive) clkIn cycles. Supports RUN,
// STOP and single-STEP modes. A new divide setting is taken only when a
// period starts, so the high and low phases of a period are always equal
// and clkOut never glitches. Inputs are assumed already synchronised to
// clkIn.
//
// Ports
//   clkIn     in   1          source clock
//   rst_n     in   1          asynchronous reset, active low
//   devide    in   DIV_WIDTH  requested divide exponent, sampled at HIGH entry
//   mode      in   2          00 STOP, 01 RUN, 10 STEP, 11 behaves as STOP
//   step      in   1          rising edge requests one period in STEP mode
//   clkOut    out  1          generated clock (registered)
//   clkTick   out  1          one-cycle pulse on the first cycle of each high phase
//   busy      out  1          high while a period is in progress
//   cycleCnt  out  CYC_WIDTH  clkOut rising edges since reset (wraps)
// -----------------------------------------------------------------------------
module sm_clk_gen #(
    parameter int SHIFT_MIN = 16,
    parameter int DIV_WIDTH = 4,
    parameter int CYC_WIDTH = 32
) (
    input  logic                 clkIn,
    input  logic                 rst_n,
    input  logic [DIV_WIDTH-1:0] devide,
    input  logic [1:0]           mode,
    input  logic                 step,
    output logic                 clkOut,
    output logic                 clkTick,
    output logic                 busy,
    output logic [CYC_WIDTH-1:0] cycleCnt
);

    // The longest half-period is 2^HALF_W cycles, so the counter needs
    // HALF_W bits to reach its terminal value of 2^HALF_W - 1.
    localparam int HALF_RAW = SHIFT_MIN + (1 << DIV_WIDTH) - 1;
    localparam int HALF_W   = (HALF_RAW < 1) ? 1 : HALF_RAW;

    localparam logic [1:0] MODE_STOP = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HIGH = 2'b01,
        LOW  = 2'b10
    } state_t;

    state_t                 state;
    logic [HALF_W-1:0]      halfCnt;
    logic [DIV_WIDTH-1:0]   divActive;
    logic                   stepPending;
    logic                   stepPrev;

    logic                   step_edge;
    logic                   step_mode;
    logic                   stop_mode;
    logic                   start;
    logic                   terminal;
    logic                   enter_high;
    logic                   pend_next;
    logic [HALF_W:0]        half_len;
    logic [HALF_W:0]        half_last;

    assign step_mode = (mode == MODE_STEP);
    // Encoding 11 is deliberately folded into STOP.
    assign stop_mode = (mode == MODE_STOP) || (mode == 2'b11);
    assign step_edge = step & ~stepPrev;
    assign start     = (mode == MODE_RUN) || (step_mode && stepPending);

    // One bit wider than the counter so that 2^HALF_W is representable;
    // the terminal value is the low HALF_W bits of half_len - 1.
    assign half_len  = (HALF_W + 1)'(1) << (SHIFT_MIN + int'(divActive));
    assign half_last = half_len - (HALF_W + 1)'(1);
    assign terminal  = (halfCnt == half_last[HALF_W-1:0]);

    // A period starts from IDLE, or back-to-back at the last LOW cycle.
    assign enter_high = start && ((state == IDLE) || ((state == LOW) && terminal));

    // Later assignments take priority: a STOP-class mode always wins, and a
    // fresh edge in the same cycle as a consumed request stays pending.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        pend_next = stepPending;
        if (enter_high && step_mode) pend_next = 1'b0;
        if (step_edge && step_mode)  pend_next = 1'b1;
        if (stop_mode)               pend_next = 1'b0;
    end

    // clkOut, clkTick and busy are registered alongside the state so the
    // generated clock comes straight from a flop and cannot glitch.
    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            clkOut      <= 1'b0;
            clkTick     <= 1'b0;
            busy        <= 1'b0;
            cycleCnt    <= '0;
            halfCnt     <= '0;
            divActive   <= '0;
            stepPending <= 1'b0;
            stepPrev    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            stepPrev    <= step;
            stepPending <= pend_next;
            clkTick     <= 1'b0;

            if (enter_high) begin
                state     <= HIGH;
                clkOut    <= 1'b1;
                clkTick   <= 1'b1;
                busy      <= 1'b1;
                divActive <= devide;
                halfCnt   <= '0;
                cycleCnt  <= cycleCnt + CYC_WIDTH'(1);
            end else begin
                case (state)
                    IDLE: begin
                        halfCnt <= '0;
                    end
                    HIGH: begin
                        if (terminal) begin
                            state   <= LOW;
                            clkOut  <= 1'b0;
                            halfCnt <= '0;
                        end else begin
                            halfCnt <= halfCnt + HALF_W'(1);
                        end
                    end
                    LOW: begin
                        // Terminal with start pending is handled by enter_high.
                        if (terminal) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            halfCnt <= '0;
                        end else begin
                            halfCnt <= halfCnt + HALF_W'(1);
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        clkOut  <= 1'b0;
                        busy    <= 1'b0;
                        halfCnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sm_clk_gen.sv
// -----------------------------------------------------------------------------
// tb_sm_clk_gen
//
// Self-checking bench for sm_clk_gen (SHIFT_MIN = 0, CYC_WIDTH = 8 so the
// cycle counter wraps in a short run). A period-level reference model
// tracks "cycles since the period began" and the half length of the
// current period; every cycle the DUT outputs are compared against it.
// Directed scenarios add literal expectations for phase lengths and counts.
// -----------------------------------------------------------------------------
module tb_sm_clk_gen;

    localparam int SHIFT_MIN = 0;
    localparam int DIV_WIDTH = 4;
    localparam int CYC_WIDTH = 8;

    localparam logic [1:0] STOP = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] STEP = 2'b10;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [DIV_WIDTH-1:0] devide = '0;
    logic [1:0]           mode = RUN;
    logic                 step = 1'b0;
    logic                 clkOut;
    logic                 clkTick;
    logic                 busy;
    logic [CYC_WIDTH-1:0] cycleCnt;

    int total = 0;
    int bad   = 0;

    sm_clk_gen #(
        .SHIFT_MIN(SHIFT_MIN),
        .DIV_WIDTH(DIV_WIDTH),
        .CYC_WIDTH(CYC_WIDTH)
    ) dut (
        .clkIn   (clk),
        .rst_n   (rst_n),
        .devide  (devide),
        .mode    (mode),
        .step    (step),
        .clkOut  (clkOut),
        .clkTick (clkTick),
        .busy    (busy),
        .cycleCnt(cycleCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A period is 2*m_h cycles long; m_t counts cycles since it began.
    logic                 m_busy = 1'b0;
    int                   m_t    = 0;
    int                   m_h    = 1;
    logic                 m_tick = 1'b0;
    logic [CYC_WIDTH-1:0] m_cnt  = '0;
    logic                 m_pend = 1'b0;
    logic                 m_prev = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_t = 0; m_h = 1; m_tick = 1'b0;
            m_cnt = '0; m_pend = 1'b0; m_prev = 1'b0;
        end else begin
            logic edge_seen, start, period_over, consumed;
            edge_seen   = step && !m_prev;
            start       = (mode == RUN) || (mode == STEP && m_pend);
            period_over = !m_busy || (m_t == 2 * m_h - 1);
            consumed    = 1'b0;
            if (period_over && start) begin
                m_busy   = 1'b1;
                m_t      = 0;
                m_h      = 1 << (SHIFT_MIN + int'(devide));
                m_tick   = 1'b1;
                m_cnt    = m_cnt + 1'b1;
                consumed = (mode == STEP);
            end else if (period_over) begin
                m_busy = 1'b0;
                m_t    = 0;
                m_tick = 1'b0;
            end else begin
                m_t++;
                m_tick = 1'b0;
            end
            if (consumed) m_pend = 1'b0;
            if (edge_seen && mode == STEP) m_pend = 1'b1;
            if (mode == STOP || mode == 2'b11) m_pend = 1'b0;
            m_prev = step;
        end
    end

    // Continuous comparison, sampled shortly after each active edge.
    bit cmp_en = 1'b0;
    always @(posedge clk) begin
        #2;
        if (cmp_en) begin
            check("cmp_clkOut",   32'(clkOut),   32'(m_busy && (m_t < m_h)));
            check("cmp_clkTick",  32'(clkTick),  32'(m_tick));
            check("cmp_busy",     32'(busy),     32'(m_busy));
            check("cmp_cycleCnt", 32'(cycleCnt), 32'(m_cnt));
        end
    end

    // ---------------- helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick(input int limit);
        int n = 0;
        while (!clkTick && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("wait_tick", 32'(clkTick), 32'd1);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    // Counts consecutive samples at level lvl while a period is in progress,
    // starting with the current sample.
    task automatic count_run(input logic lvl, output int n);
        n = 0;
        while (clkOut == lvl && busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hi, tk, h1, l1, h2, l2;
        logic [CYC_WIDTH-1:0] c0;

        // 1: reset held with RUN requested
        cmp_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_clkOut",   32'(clkOut),   32'd0);
            check("rst_clkTick",  32'(clkTick),  32'd0);
            check("rst_busy",     32'(busy),     32'd0);
            check("rst_cycleCnt", 32'(cycleCnt), 32'd0);
        end
        rst_n = 1'b1;

        // 2: minimum period, 20 cycles
        hi = 0; tk = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("first_clkOut",  32'(clkOut),  32'd1);
                check("first_clkTick", 32'(clkTick), 32'd1);
            end
            hi += int'(clkOut);
            tk += int'(clkTick);
        end
        check("run20_cycleCnt", 32'(cycleCnt), 32'd10);
        check("run20_highs",    32'(hi),       32'd10);
        check("run20_ticks",    32'(tk),       32'd10);

        // 3: divide change mid high phase
        mode = STOP;
        wait_idle(50);
        devide = 4'd2;
        mode = RUN;
        wait_tick(50);
        @(negedge clk);
        devide = 4'd1;
        count_run(1'b1, h1);
        count_run(1'b0, l1);
        count_run(1'b1, h2);
        count_run(1'b0, l2);
        check("div_hi4", 32'(h1 + 1), 32'd4);
        check("div_lo4", 32'(l1),     32'd4);
        check("div_hi2", 32'(h2),     32'd2);
        check("div_lo2", 32'(l2),     32'd2);

        // 4a: single step
        mode = STOP;
        wait_idle(50);
        mode = STEP;
        c0 = cycleCnt;
        pulse_step();
        wait_tick(10);
        count_run(1'b1, h1);
        count_run(1'b0, l1);
        check("step_hi", 32'(h1), 32'd2);
        check("step_lo", 32'(l1), 32'd2);
        check("step_idle_busy", 32'(busy), 32'd0);
        check("step_cnt", 32'(cycleCnt), 32'(c0 + 1'b1));

        // 4b: three edges inside one period give two periods
        c0 = cycleCnt;
        pulse_step();
        pulse_step();
        pulse_step();
        cycles(20);
        check("step3_cnt",  32'(cycleCnt), 32'(c0 + 2'd2));
        check("step3_busy", 32'(busy),     32'd0);

        // 4c: edges while in RUN are ignored
        mode = RUN;
        pulse_step();
        pulse_step();
        mode = STEP;
        wait_idle(50);
        c0 = cycleCnt;
        cycles(20);
        check("runedge_cnt",  32'(cycleCnt), 32'(c0));
        check("runedge_busy", 32'(busy),     32'd0);

        // 5: STOP on cycle 3 of an 8-cycle high phase
        mode = STOP;
        devide = 4'd3;
        mode = RUN;
        wait_tick(50);
        cycles(2);
        mode = STOP;
        count_run(1'b1, h1);
        count_run(1'b0, l1);
        check("stop_hi8", 32'(h1 + 2), 32'd8);
        check("stop_lo8", 32'(l1),     32'd8);
        cycles(10);
        check("stop_clkOut", 32'(clkOut), 32'd0);
        check("stop_busy",   32'(busy),   32'd0);

        // 6: asynchronous reset in the middle of a high phase
        devide = 4'd2;
        mode = RUN;
        wait_tick(50);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clkOut",   32'(clkOut),   32'd0);
        check("async_cycleCnt", 32'(cycleCnt), 32'd0);
        check("async_busy",     32'(busy),     32'd0);
        cycles(2);
        rst_n = 1'b1;
        wait_tick(10);
        check("restart_cnt", 32'(cycleCnt), 32'd1);

        // cycle counter wrap: 256 periods of 2 cycles from reset
        rst_n = 1'b0;
        devide = 4'd0;
        cycles(2);
        rst_n = 1'b1;
        cycles(512);
        check("wrap_cnt0", 32'(cycleCnt), 32'd0);
        cycles(1);
        check("wrap_cnt1", 32'(cycleCnt), 32'd1);

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: mode = RUN;
                    4, 5, 6:    mode = STEP;
                    7, 8:       mode = STOP;
                    default:    mode = 2'b11;
                endcase
            end
            if ($urandom_range(0, 19) == 0) devide = DIV_WIDTH'($urandom_range(0, 3));
            step = ($urandom_range(0, 3) == 0);
        end
        step = 1'b0;
        mode = STOP;
        cycles(40);
        check("final_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
